// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF->ID boundary buffer.
// Entry layout, default NOP encoding and pointer sizing helper.
package if_id_pkg;

   localparam logic [31:0] NOP_RV32 = 32'h00000013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_inc;
   } if_id_entry_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/if_id_fifo_mem.sv
// Entry storage for the IF->ID buffer: DEPTH x W registers,
// one synchronous write port and one asynchronous read port.
module if_id_fifo_mem
   import if_id_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 96,
   parameter int AW    = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // Contents are never cleared; readers mask with occupancy.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_pipe_buffer.sv
// Elastic IF->ID buffer with valid/ready on both sides and flush.
// Optional stall counter enabled by defining IFID_STALL_CNT_EN.
module if_id_pipe_buffer
   import if_id_pkg::*;
#(
   parameter int                INSTR_W   = 32,
   parameter int                PC_W      = 32,
   parameter int                DEPTH     = 2,
   parameter logic [PC_W-1:0]    PC_INC    = 4,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_RV32)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_W-1:0]     in_instr,
   input  logic [PC_W-1:0]        in_pc,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_W-1:0]     out_instr,
   output logic [PC_W-1:0]        out_pc,
   output logic [PC_W-1:0]        out_pc_inc,
   output logic [$clog2(DEPTH):0] count
`ifdef IFID_STALL_CNT_EN
   ,
   output logic [31:0]            stall_cnt
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = INSTR_W + 2 * PC_W;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [EW-1:0] wdata, rdata;

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign wdata     = {in_instr, in_pc, in_pc + PC_INC};

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   if_id_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (EW),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   always_comb begin
      out_instr  = NOP_INSTR;
      out_pc     = '0;
      out_pc_inc = '0;
      if (out_valid) begin
         {out_instr, out_pc, out_pc_inc} = rdata;
      end
   end

   assign count = count_q;

`ifdef IFID_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Counts fetch-side backpressure; a redirect does not reset it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (in_valid && !in_ready) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_buffer.sv
// Directed plus randomized bench for if_id_pipe_buffer,
// compared against a queue-based model of the buffer.
module tb_if_id_pipe_buffer;
   import if_id_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_inc;
   logic [1:0]  count;
`ifdef IFID_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   if_id_entry_t mq[$];
   int unsigned  m_stall = 0;

   always #5 clk = ~clk;

   if_id_pipe_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .out_pc_inc (out_pc_inc),
      .count      (count)
`ifdef IFID_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] e_i, e_p, e_pi;
      e_i  = NOP_RV32;
      e_p  = 32'h0;
      e_pi = 32'h0;
      if (mq.size() != 0) begin
         e_i  = mq[0].instr;
         e_p  = mq[0].pc;
         e_pi = mq[0].pc_inc;
      end
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("out_instr", out_instr, e_i);
      chk("out_pc", out_pc, e_p);
      chk("out_pc_inc", out_pc_inc, e_pi);
`ifdef IFID_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
   endtask

   // Check current outputs, advance the model, then one clock.
   task automatic cycle();
      bit full, push, pop;
      if_id_entry_t e;
      check_all();
      if (reset) begin
         mq.delete();
         m_stall = 0;
      end else begin
         full = (mq.size() == DEPTH);
         push = in_valid && !full;
         pop  = (mq.size() != 0) && out_ready;
         if (in_valid && full) m_stall++;
         if (flush) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
               e.instr  = in_instr;
               e.pc     = in_pc;
               e.pc_inc = in_pc + 32'd4;
               mq.push_back(e);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic [31:0] ins);
      in_valid = v;
      in_pc    = pc;
      in_instr = ins;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      cycle();
      cycle();
      reset = 1'b0;
      // idle after reset
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_nop", out_instr, 32'h00000013);
      chk("rst_count", 32'(count), 32'd0);
      cycle();

      // single push, visible one cycle later
      drive(1'b1, 32'h100, 32'hDEADBEEF);
      cycle();
      drive(1'b0, 32'h0, 32'h0);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_pc", out_pc, 32'h100);
      chk("t2_pc_inc", out_pc_inc, 32'h104);
      chk("t2_instr", out_instr, 32'hDEADBEEF);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;

      // fill, hold third, then drain in order
      drive(1'b1, 32'h200, 32'hA0);
      cycle();
      drive(1'b1, 32'h204, 32'hA1);
      cycle();
      drive(1'b1, 32'h208, 32'hA2);
      chk("t3_full", 32'(in_ready), 32'd0);
      cycle();
      cycle();
      chk("t3_head", out_pc, 32'h200);
      out_ready = 1'b1;
      cycle();
      chk("t3_second", out_pc, 32'h204);
      out_ready = 1'b0;
      cycle();
      drive(1'b0, 32'h0, 32'h0);
      chk("t3_held_pushed", 32'(count), 32'd2);
      out_ready = 1'b1;
      cycle();
      chk("t3_third", out_pc, 32'h208);

      // count=1: push+pop together
      drive(1'b1, 32'h300, 32'hB0);
      cycle();
      chk("t4_count", 32'(count), 32'd1);
      chk("t4_head", out_pc, 32'h300);
      drive(1'b0, 32'h0, 32'h0);
      out_ready = 1'b0;

      // flush with a full buffer and a pending push
      drive(1'b1, 32'h400, 32'hC0);
      cycle();
      chk("t5_pre", 32'(count), 32'd2);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_valid", 32'(out_valid), 32'd0);
      cycle();

      // PC wrap on link computation
      drive(1'b1, 32'hFFFFFFFC, 32'hD0);
      cycle();
      drive(1'b0, 32'h0, 32'h0);
      chk("t6_pc_inc", out_pc_inc, 32'h0);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;

`ifdef IFID_STALL_CNT_EN
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      drive(1'b1, 32'h500, 32'hE0);
      cycle();
      cycle();
      repeat (5) cycle();
      chk("stall5", stall_cnt, 32'd5);
      drive(1'b0, 32'h0, 32'h0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("stall_flush", stall_cnt, 32'd5);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom);
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         cycle();
      end
      drive(1'b0, 32'h0, 32'h0);
      flush = 1'b0;
      out_ready = 1'b0;
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
